// File: rtl/frame_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_bus_pkg
// Description : Shared frame geometry, word width and pointer types for the
//               frame_bus frame-buffer bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_bus_pkg;

  localparam int FRAME_W = 320;               // pixels per line
  localparam int FRAME_H = 240;               // lines per frame
  localparam int DATA_W  = 32;                // word width
  localparam int DEPTH   = FRAME_W * FRAME_H; // RAM words / pointer wrap point
  localparam int ADDR_W  = 19;                // pointer width, 2**19 >= 76800

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : frame_bus_pkg
`default_nettype wire

// File: rtl/frame_bus_spram.sv
`default_nettype none
// ============================================================================
// Module      : frame_bus_spram
// Description : Single-port RAM, DEPTH x DATA_W, with a registered read port.
//               A read is performed only when i_re is high and no write is
//               taking place, so o_rdata holds its value between reads.
// Ports       : clk      - clock, rising edge
//               reset_n  - synchronous active-low reset (clears o_rdata only)
//               i_we     - write enable
//               i_re     - read enable
//               i_addr   - word address
//               i_wdata  - write data
//               o_rdata  - registered read data (one cycle after i_re)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bus_spram
  import frame_bus_pkg::*;
#(
  parameter int DEPTH  = frame_bus_pkg::DEPTH,
  parameter int RAM_AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [RAM_AW-1:0] i_addr,
  input  data_t             i_wdata,
  output data_t             o_rdata
);

  data_t r_mem [DEPTH];
  data_t r_rdata;

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : frame_bus_spram
`default_nettype wire

// File: rtl/frame_bus.sv
`default_nettype none
// ============================================================================
// Module      : frame_bus
// Description : Frame-buffer bridge. Capture words are written at an
//               auto-incrementing write pointer; readout streams them back at
//               an independent auto-incrementing read pointer. Both share one
//               RAM port, writes having fixed priority over reads.
// Ports       : ctrl_clk  - sole clock, rising edge
//               reset_n   - synchronous active-low reset
//               iData     - write word
//               iValid    - write request
//               read_init - read request (one word per cycle while high)
//               oData     - read word (holds between reads)
//               oValid    - oData valid this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bus
  import frame_bus_pkg::*;
#(
  parameter int DEPTH = frame_bus_pkg::DEPTH
) (
  input  logic  ctrl_clk,
  input  logic  reset_n,
  input  data_t iData,
  input  logic  iValid,
  input  logic  read_init,
  output data_t oData,
  output logic  oValid
);

  localparam int    c_RAM_AW = $clog2(DEPTH);
  localparam addr_t c_LAST   = addr_t'(DEPTH - 1);

  addr_t r_wr_ptr;
  addr_t r_rd_ptr;
  logic  r_valid;

  logic  w_wr_grant;
  logic  w_rd_grant;
  logic  w_ram_we;

  // Write always wins the single port; a losing read is simply dropped and
  // the requester retries by holding read_init.
  assign w_wr_grant = iValid;
  assign w_rd_grant = read_init & ~iValid;

  // Reset must override a same-cycle write request.
  assign w_ram_we = w_wr_grant & reset_n;

  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_grant) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + addr_t'(1);
      end
      if (w_rd_grant) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + addr_t'(1);
      end
      // Valid tracks the RAM's one-cycle registered read.
      r_valid <= w_rd_grant;
    end
  end

  frame_bus_spram #(
    .DEPTH  (DEPTH),
    .RAM_AW (c_RAM_AW)
  ) u_spram (
    .clk     (ctrl_clk),
    .reset_n (reset_n),
    .i_we    (w_ram_we),
    .i_re    (w_rd_grant),
    .i_addr  (w_wr_grant ? r_wr_ptr[c_RAM_AW-1:0] : r_rd_ptr[c_RAM_AW-1:0]),
    .i_wdata (iData),
    .o_rdata (oData)
  );

  assign oValid = r_valid;

endmodule : frame_bus
`default_nettype wire

// File: tb/tb_frame_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_bus
// Description : Directed bench for frame_bus. A full-size instance and a
//               DEPTH=16 instance share one stimulus stream; each step checks
//               the outputs of the instance under test against hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_bus;

  logic        clk;
  logic        rst_n;
  logic [31:0] iData;
  logic        iValid;
  logic        read_init;
  logic [31:0] big_data;
  logic        big_valid;
  logic [31:0] sm_data;
  logic        sm_valid;

  int errors;
  int checks;

  frame_bus u_big (
    .ctrl_clk  (clk),
    .reset_n   (rst_n),
    .iData     (iData),
    .iValid    (iValid),
    .read_init (read_init),
    .oData     (big_data),
    .oValid    (big_valid)
  );

  frame_bus #(.DEPTH(16)) u_small (
    .ctrl_clk  (clk),
    .reset_n   (rst_n),
    .iData     (iData),
    .iValid    (iValid),
    .read_init (read_init),
    .oData     (sm_data),
    .oValid    (sm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    iValid    = v;
    iData     = d;
    read_init = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_big(input string tag, input logic ev, input logic [31:0] ed);
    checks++;
    assert (big_valid === ev) else begin
      errors++;
      $error("FAIL %s oValid observed=%0b expected=%0b", tag, big_valid, ev);
    end
    checks++;
    assert (big_data === ed) else begin
      errors++;
      $error("FAIL %s oData observed=%0h expected=%0h", tag, big_data, ed);
    end
  endtask

  task automatic chk_small(input string tag, input logic ev, input logic [31:0] ed);
    checks++;
    assert (sm_valid === ev) else begin
      errors++;
      $error("FAIL %s oValid observed=%0b expected=%0b", tag, sm_valid, ev);
    end
    checks++;
    assert (sm_data === ed) else begin
      errors++;
      $error("FAIL %s oData observed=%0h expected=%0h", tag, sm_data, ed);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    chk_big("reset", 1'b0, 32'd0);
    chk_small("reset_s", 1'b0, 32'd0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    iValid    = 1'b0;
    iData     = '0;
    read_init = 1'b0;

    // Power-on reset, then idle: outputs stay cleared.
    step(1'b0, 32'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 1'b0);
      chk_big("idle", 1'b0, 32'd0);
      chk_small("idle_s", 1'b0, 32'd0);
    end

    // Stream 0..19 in, then back out one word per cycle.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b0);
      chk_big("write_phase", 1'b0, 32'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk_big("stream_rd", 1'b1, 32'(i));
    end
    step(1'b0, 32'd0, 1'b0);
    chk_big("stream_end", 1'b0, 32'd19);

    // Write preempts a held read; no skip or duplicate, 0xAA lands at addr 4.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b0, 32'd0, 1'b1);     chk_big("preempt_rd0", 1'b1, 32'd0);
    step(1'b0, 32'd0, 1'b1);     chk_big("preempt_rd1", 1'b1, 32'd1);
    step(1'b1, 32'hAA, 1'b1);    chk_big("preempt_lost", 1'b0, 32'd1);
    step(1'b0, 32'd0, 1'b1);     chk_big("preempt_rd2", 1'b1, 32'd2);
    step(1'b0, 32'd0, 1'b1);     chk_big("preempt_rd3", 1'b1, 32'd3);
    step(1'b0, 32'd0, 1'b1);     chk_big("preempt_rd4", 1'b1, 32'hAA);
    step(1'b0, 32'd0, 1'b0);     chk_big("preempt_end", 1'b0, 32'hAA);

    // DEPTH=16: 18 writes wrap and overwrite addresses 0 and 1.
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 32'(100 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk_small("wr_wrap", 1'b1, (i < 2) ? 32'(116 + i) : 32'(100 + i));
    end

    // DEPTH=16: 18 reads wrap the read pointer.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk_small("rd_wrap", 1'b1, 32'(i % 16));
    end

    // Reset mid-stream: in-flight read dropped, same-cycle write ignored,
    // RAM retained, read restarts at address 0.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'(50 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk_big("pre_rst_rd", 1'b1, 32'(50 + i));
    end
    rst_n = 1'b0;
    step(1'b1, 32'hDEAD, 1'b1);
    rst_n = 1'b1;
    chk_big("mid_reset", 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b1);     chk_big("post_rst_rd0", 1'b1, 32'd50);
    step(1'b0, 32'd0, 1'b1);     chk_big("post_rst_rd1", 1'b1, 32'd51);
    step(1'b0, 32'd0, 1'b0);     chk_big("post_rst_idle", 1'b0, 32'd51);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_frame_bus
`default_nettype wire
